// File: rtl/ahb_rr_burst_arbiter.sv
// Round-robin AHB bus arbiter with burst-aware grant hold.
// A master keeps the slave for a whole burst; the grant moves on only when the
// final beat completes, and the next owner may take over at that same edge.
//
// state | meaning
// IDLE  | no master granted, waiting for any request
// BURST | one master owns the slave until its last beat completes
module ahb_rr_burst_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int INCR_MAX   = 16,
  localparam int MW = ($clog2(MASTER_NUM) > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [MASTER_NUM-1:0]   hreq,
  input  logic [MASTER_NUM*3-1:0] hburst,
  input  logic                    hwait,
  output logic [MASTER_NUM-1:0]   hgrant,
  output logic                    hsel,
  output logic [MW-1:0]           hmaster,
  output logic                    hlast
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] INCR_LAST = 4'(INCR_MAX - 1);
  localparam logic [2:0] B_SINGLE  = 3'd0;
  localparam logic [2:0] B_INCR    = 3'd1;

  state_t                  state_q, state_d;
  logic [MASTER_NUM-1:0]   grant_q, grant_d;
  logic [MW-1:0]           master_q, master_d;
  logic [MW-1:0]           ptr_q, ptr_d;
  logic [2:0]              burst_q, burst_d;
  logic [3:0]              count_q, count_d;

  logic [4:0]              limit;
  logic                    hlast_c;
  logic [MW-1:0]           arb_ptr;
  logic [MW-1:0]           cand;
  logic                    win_found;
  logic [MW-1:0]           win_idx;
  logic [2:0]              win_burst;

  // Beat limit of the latched burst type
  always_comb begin
    limit = 5'd1;
    case (burst_q)
      3'd0:       limit = 5'd1;
      3'd1:       limit = 5'(INCR_MAX);
      3'd2, 3'd3: limit = 5'd4;
      3'd4, 3'd5: limit = 5'd8;
      default:    limit = 5'd16;
    endcase
  end

  // Final-beat flag; undefined-length INCR also ends when its owner drops hreq
  always_comb begin
    hlast_c = 1'b0;
    if (state_q == BURST) begin
      if (burst_q == B_INCR)
        hlast_c = (count_q == INCR_LAST) || !hreq[master_q];
      else
        hlast_c = ({1'b0, count_q} == (limit - 5'd1));
    end
  end

  // Round-robin search starting one past the pointer; at burst end the
  // current owner becomes the pointer so the search can run at the same edge
  always_comb begin
    arb_ptr   = (state_q == BURST) ? master_q : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    win_burst = B_SINGLE;
    cand      = '0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      cand = MW'((int'(arb_ptr) + i) % MASTER_NUM);
      if (!win_found && hreq[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_burst = hburst[int'(cand)*3 +: 3];
      end
    end
  end

  // Next-state: grant on request, count completed beats, hand over on last beat
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    count_d  = count_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        state_d          = BURST;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        master_d         = win_idx;
        burst_d          = win_burst;
        count_d          = '0;
      end
    end else if (!hwait) begin
      if (hlast_c) begin
        ptr_d = master_q;
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          master_d         = win_idx;
          burst_d          = win_burst;
          count_d          = '0;
        end else begin
          state_d  = IDLE;
          grant_d  = '0;
          master_d = '0;
          count_d  = '0;
        end
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // State registers; reset gives master 0 first priority
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= MW'(MASTER_NUM - 1);
      burst_q  <= B_SINGLE;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      count_q  <= count_d;
    end
  end

  assign hgrant  = grant_q;
  assign hsel    = |grant_q;
  assign hmaster = master_q;
  assign hlast   = hlast_c;

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Scoreboard bench for ahb_rr_burst_arbiter: directed scenarios then random traffic.
module tb_ahb_rr_burst_arbiter;
  localparam int N  = 4;
  localparam int IM = 16;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] hreq;
  logic [N*3-1:0] hburst;
  logic         hwait;
  logic [N-1:0] hgrant;
  logic         hsel;
  logic [1:0]   hmaster;
  logic         hlast;

  ahb_rr_burst_arbiter #(.MASTER_NUM(N), .INCR_MAX(IM)) dut (
    .hclk(hclk), .hreset(hreset), .hreq(hreq), .hburst(hburst), .hwait(hwait),
    .hgrant(hgrant), .hsel(hsel), .hmaster(hmaster), .hlast(hlast)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         s;
    logic [1:0]   m;
    logic         l;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who owns the bus, how many beats done, burst length
  int m_owner = -1;
  int m_beats = 0;
  int m_len   = 1;
  bit m_incr  = 0;
  int m_ptr   = N - 1;

  function automatic int burst_len(input logic [2:0] b);
    int tbl [8] = '{1, IM, 4, 4, 8, 8, 16, 16};
    return tbl[b];
  endfunction

  function automatic bit model_last();
    if (m_owner < 0) return 1'b0;
    if (m_incr) return (m_beats == IM - 1) || !hreq[m_owner];
    return m_beats == m_len - 1;
  endfunction

  // Advance model across a clock edge using the inputs present at that edge
  task automatic model_edge();
    bit last;
    last = model_last();
    if (hreset) begin
      m_owner = -1; m_beats = 0; m_ptr = N - 1;
    end else if (m_owner < 0 || (last && !hwait)) begin
      if (m_owner >= 0) m_ptr = m_owner;
      m_owner = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && hreq[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        logic [2:0] b;
        b = hburst[m_owner*3 +: 3];
        m_beats = 0;
        m_len   = burst_len(b);
        m_incr  = (b == 3'd1);
      end
    end else if (!hwait) begin
      m_beats++;
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N*3-1:0] bu,
                      input logic wt, input logic rs);
    exp_t e;
    @(posedge hclk);
    model_edge();
    #1;
    hreq = rq; hburst = bu; hwait = wt; hreset = rs;
    e.g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.s = (m_owner >= 0);
    e.m = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.l = model_last();
    sb.push_back(e);
  endtask

  task automatic dchk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare with the DUT outputs
  initial begin
    exp_t e, o;
    forever begin
      @(negedge hclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        o = '{g: hgrant, s: hsel, m: hmaster, l: hlast};
        n_cmp++;
        if (o !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got g=%b s=%b m=%0d l=%b expected g=%b s=%b m=%0d l=%b",
                   $time, o.g, o.s, o.m, o.l, e.g, e.s, e.m, e.l);
        end
        n_cmp++;
        if (!$onehot0(hgrant)) begin
          n_bad++;
          $display("FAIL onehot @%0t: got g=%b expected at most one bit", $time, hgrant);
        end
      end
    end
  end

  task automatic do_reset();
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [N*3-1:0] bset(input int m, input logic [2:0] b);
    logic [N*3-1:0] v;
    v = '0;
    v[m*3 +: 3] = b;
    return v;
  endfunction

  initial begin
    int cnt;
    logic [N*3-1:0] bu;
    hreset = 1'b1; hreq = '0; hburst = '0; hwait = 1'b0;

    // Reset release, INCR4 for master 0 then master 2 back-to-back
    do_reset();
    #3 dchk("reset_grant", hgrant, 0);
    step(4'b0101, bset(0, 3'd3), 1'b0, 1'b0);
    #3 dchk("idle_before_grant", hgrant, 0);
    for (int g = 0; g < 4; g++) begin
      step(4'b0101, bset(0, 3'd3), 1'b0, 1'b0);
      #3 dchk("incr4_grant", hgrant, 1);
      if (g == 3) dchk("incr4_hlast", hlast, 1);
    end
    step(4'b0000, '0, 1'b0, 1'b0);
    #3 dchk("b2b_grant_m2", hgrant, 4);

    // All masters SINGLE: one grant per cycle in rotation
    do_reset();
    step(4'b1111, '0, 1'b0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, '0, 1'b0, 1'b0);
      #3 dchk("rr_single", hgrant, 1 << (g % 4));
    end

    // WRAP8 on master 1 with three wait cycles
    do_reset();
    cnt = 0;
    step(4'b0010, bset(1, 3'd4), 1'b0, 1'b0);
    for (int g = 0; g < 14; g++) begin
      step((g < 1) ? 4'b0010 : 4'b0000, bset(1, 3'd4), (g >= 5 && g < 8), 1'b0);
      #3 if (hgrant == 4'b0010) cnt++;
      if (g == 10) dchk("wrap8_hlast", hlast, 1);
    end
    dchk("wrap8_span", cnt, 11);

    // INCR on master 2 released by dropping hreq
    do_reset();
    step(4'b0100, bset(2, 3'd1), 1'b0, 1'b0);
    for (int g = 0; g < 9; g++) begin
      step((g < 6) ? 4'b0100 : 4'b0000, bset(2, 3'd1), 1'b0, 1'b0);
      #3 if (g == 6) dchk("incr_drop_hlast", hlast, 1);
      if (g == 7) dchk("incr_drop_release", hgrant, 0);
    end

    // INCR with hreq held: forced end at INCR_MAX beats
    do_reset();
    step(4'b0100, bset(2, 3'd1), 1'b0, 1'b0);
    for (int g = 0; g < 18; g++) begin
      step((g < 16) ? 4'b0100 : 4'b0000, bset(2, 3'd1), 1'b0, 1'b0);
      #3 if (g == 15) dchk("incr_cap_hlast", hlast, 1);
      if (g == 14) dchk("incr_cap_not_last", hlast, 0);
    end

    // INCR16 on master 3: hreq dropped and hburst changed mid-burst
    do_reset();
    cnt = 0;
    step(4'b1000, bset(3, 3'd7), 1'b0, 1'b0);
    for (int g = 0; g < 20; g++) begin
      bu = (g < 3) ? bset(3, 3'd7) : bset(3, 3'd0);
      step((g < 2) ? 4'b1000 : 4'b0000, bu, 1'b0, 1'b0);
      #3 if (hgrant == 4'b1000) cnt++;
      if (g == 15) dchk("incr16_hlast", hlast, 1);
    end
    dchk("incr16_span", cnt, 16);

    // Reset in the middle of INCR8
    do_reset();
    step(4'b0001, bset(0, 3'd5), 1'b0, 1'b0);
    step(4'b0001, bset(0, 3'd5), 1'b0, 1'b0);
    step(4'b0001, bset(0, 3'd5), 1'b0, 1'b0);
    step(4'b0001, bset(0, 3'd5), 1'b0, 1'b1);
    step(4'b1111, '0, 1'b0, 1'b0);
    #3 dchk("reset_abort_grant", hgrant, 0);
    dchk("reset_abort_hlast", hlast, 0);
    step(4'b1111, '0, 1'b0, 1'b0);
    #3 dchk("post_reset_m0", hgrant, 1);

    // Random traffic against the model
    for (int t = 0; t < 600; t++) begin
      step(N'($urandom), (N*3)'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) == 0));
    end

    @(posedge hclk);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge hclk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
